counter_cmd_seq: RTL and testbench
==================================

# counter_cmd_seq

Command sequencer that sits directly upstream of the up-counter and drives its `cen`/`wen`/`dat` controls. Software or a testbench pushes LOAD / RUN / NOP / ABORT commands through a valid/ready port into a small FIFO. The block replays them as cycle-exact counter-control waveforms: one-cycle loads, N-cycle count bursts, and idle slots. All outputs are registered so they can feed the counter's posedge and negedge registers directly.

## Interface
- `WIDTH`, 8, width of `cmd_arg`, `dat` and the internal run-length counter; matches the counter's `WIDTH`.
- `DEPTH`, 4, command FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock; all state on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; `= (level != DEPTH)`.
- `cmd_op`  in  2  00 NOP, 01 LOAD, 10 RUN, 11 ABORT.
- `cmd_arg`  in  WIDTH  LOAD value or RUN length.
- `cen`  out  1  counter enable to counter (registered).
- `wen`  out  1  counter write enable (registered).
- `dat`  out  WIDTH  counter load data (registered).
- `done`  out  1  one-cycle pulse on final output cycle of a LOAD or RUN.
- `busy`  out  1  FIFO non-empty or an output cycle in progress.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Accept on the posedge where `cmd_valid && cmd_ready`. NOP, LOAD and RUN are written into the FIFO as {op, arg}.
- ABORT is not queued. On acceptance it empties the FIFO, terminates any LOAD/RUN in progress and forces state IDLE. Any pop in the same cycle is discarded. `done` is not pulsed.
- States:
  - IDLE: all outputs 0. If FIFO is non-empty, pop head and go to the op's state.
  - LOAD: exactly one cycle with `wen=1`, `dat=arg`, `cen=0`, `done=1`.
  - RUN: `cen=1` for exactly `arg` consecutive cycles; `wen=0`, `dat=0`; `done=1` on the last of those cycles.
  - SLOT: one cycle with all outputs 0, used by NOP and by RUN with `arg=0`. No `done` is pulsed.
- Back-to-back: in the final cycle of LOAD, RUN or SLOT, the next FIFO head (if any) is popped. Its first output cycle therefore follows with no gap. With the FIFO empty, the state returns to IDLE.
- Run-length counter is WIDTH bits, loaded with `arg` and decremented per `cen` cycle. RUN `2^WIDTH-1` is the maximum and must not wrap.
- `cen` and `wen` are never both 1. `dat` is 0 whenever `wen=0`.
- `busy = (level != 0) | cen | wen | (state == SLOT)`.
- FIFO push and pop in the same cycle leaves `level` unchanged. Push is impossible when full, since `cmd_ready=0`. A pop never sees the entry being pushed in the same cycle.

## Timing
- Reset (`rst_n=0`, asynchronous): `cen=0`, `wen=0`, `dat=0`, `done=0`, `busy=0`, `level=0`, state IDLE, FIFO empty. `cmd_ready` reads 1 throughout reset and after.
- Reset asserted mid-RUN or mid-LOAD: outputs drop to 0 immediately, without waiting for a clock edge. Queued commands are lost.
- Latency into an idle, empty block:
  - command accepted at edge k;
  - FIFO holds it after edge k;
  - popped at edge k+1;
  - first output cycle visible after edge k+2 (2 cycles, accept to output).
- Throughput: one output cycle per clock, sustained, while the FIFO stays non-empty.
- ABORT accepted at edge k: after edge k, `cen=wen=0`, `level=0`, `busy=0`.
- `cmd_ready` is combinational from `level` only. It has no path from `cmd_valid`.

## Test plan
- Reset then LOAD 0x5A, edge 0: `wen=1`, `dat=0x5A`, `done=1` for one cycle after edge 2; `busy` returns to 0 after edge 3.
- LOAD 0x10, RUN 3, NOP, RUN 2 pushed back-to-back:
  - outputs per cycle: wen, cen, cen, cen, idle, cen, cen, with no gaps;
  - `done` pulses on the wen cycle, the 3rd cen cycle and the 2nd cen cycle.
- Push 5 RUN 200 commands with DEPTH=4:
  - `cmd_ready` drops when `level=4`;
  - 5th command is accepted only after the first pop;
  - total `cen` cycles = 1000.
- RUN 250 with 2 commands queued, then ABORT at the 10th `cen` cycle: exactly 10 `cen` cycles; `level=0`, `busy=0` next cycle; no `done`.
- RUN 0 then LOAD 7: one all-zero slot, then a `wen` cycle with `dat=7`. `done` pulses only for the LOAD.
- `rst_n` pulsed low for half a cycle mid-RUN 100: `cen` falls immediately; `level=0`; a subsequent LOAD 1 behaves exactly as in the first scenario.

Source files
------------

// File: rtl/counter_cmd_seq.sv
// counter_cmd_seq: queues LOAD/RUN/NOP commands in a small FIFO and replays
// them as registered cen/wen/dat waveforms for a downstream up-counter.
module counter_cmd_seq #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [WIDTH-1:0]         cmd_arg,
    output logic                     cen,
    output logic                     wen,
    output logic [WIDTH-1:0]         dat,
    output logic                     done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_RUN   = 2'b10,
        OP_ABORT = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_SLOT
    } state_t;

    logic [WIDTH+1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] arg_q;
    logic [WIDTH-1:0] arg_nxt;
    logic             slot_q;
    logic             accept;
    logic             abort;
    logic             push;
    logic             pop;
    logic             last;
    logic             cen_nxt;
    logic             wen_nxt;
    logic             done_nxt;
    logic             slot_nxt;
    logic [WIDTH-1:0] dat_nxt;
    logic [WIDTH+1:0] head;
    op_t              head_op;
    logic [WIDTH-1:0] head_arg;

    assign cmd_ready = (level != (AW+1)'(DEPTH));
    assign accept    = cmd_valid & cmd_ready;
    assign abort     = accept & (cmd_op == OP_ABORT);
    assign push      = accept & ~abort;
    assign head      = mem[rd_ptr];
    assign head_op   = op_t'(head[WIDTH+1:WIDTH]);
    assign head_arg  = head[WIDTH-1:0];

    // The state register holds the cycle being prepared; the output registers
    // present it one edge later, so pop -> first output is one extra cycle and
    // back-to-back commands still stream with no gap. The state != S_IDLE term
    // keeps busy high across the cycle between a pop and its first output.
    assign busy = (level != '0) | cen | wen | slot_q | (state != S_IDLE);

    // Next-state, run-length update, FIFO pop and next output values
    always_comb begin
        state_nxt = state;
        arg_nxt   = arg_q;
        pop       = 1'b0;
        last      = 1'b0;
        cen_nxt   = 1'b0;
        wen_nxt   = 1'b0;
        done_nxt  = 1'b0;
        slot_nxt  = 1'b0;
        dat_nxt   = '0;
        case (state)
            S_LOAD: begin
                wen_nxt  = 1'b1;
                dat_nxt  = arg_q;
                done_nxt = 1'b1;
                last     = 1'b1;
            end
            S_RUN: begin
                cen_nxt = 1'b1;
                arg_nxt = arg_q - WIDTH'(1);
                if (arg_q == WIDTH'(1)) begin
                    done_nxt = 1'b1;
                    last     = 1'b1;
                end
            end
            S_SLOT: begin
                slot_nxt = 1'b1;
                last     = 1'b1;
            end
            default: last = 1'b1;
        endcase
        if (last) begin
            state_nxt = S_IDLE;
            if (level != '0) begin
                pop     = 1'b1;
                arg_nxt = head_arg;
                case (head_op)
                    OP_LOAD: state_nxt = S_LOAD;
                    OP_RUN:  state_nxt = (head_arg == '0) ? S_SLOT : S_RUN;
                    default: state_nxt = S_SLOT;
                endcase
            end
        end
        if (abort) begin
            state_nxt = S_IDLE;
            arg_nxt   = '0;
            pop       = 1'b0;
            cen_nxt   = 1'b0;
            wen_nxt   = 1'b0;
            done_nxt  = 1'b0;
            slot_nxt  = 1'b0;
            dat_nxt   = '0;
        end
    end

    // State, run-length and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            arg_q  <= '0;
            cen    <= 1'b0;
            wen    <= 1'b0;
            done   <= 1'b0;
            dat    <= '0;
            slot_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            arg_q  <= arg_nxt;
            cen    <= cen_nxt;
            wen    <= wen_nxt;
            done   <= done_nxt;
            dat    <= dat_nxt;
            slot_q <= slot_nxt;
        end
    end

    // FIFO pointers and occupancy; ABORT flushes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (abort) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_op, cmd_arg};
    end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Directed bench for counter_cmd_seq with hand-computed expectations.
module tb_counter_cmd_seq;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       cen;
    logic       wen;
    logic [7:0] dat;
    logic       done;
    logic       busy;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    counter_cmd_seq #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cen       (cen),
        .wen       (wen),
        .dat       (dat),
        .done      (done),
        .busy      (busy),
        .level     (level)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic load_test(input string pfx, input logic [7:0] v);
        push(2'b01, v);
        chk({pfx, "_e0_level"}, level, 1);
        chk({pfx, "_e0_wen"}, wen, 0);
        tick();
        chk({pfx, "_e1_wen"}, wen, 0);
        chk({pfx, "_e1_level"}, level, 0);
        tick();
        chk({pfx, "_e2_wen"}, wen, 1);
        chk({pfx, "_e2_dat"}, dat, v);
        chk({pfx, "_e2_done"}, done, 1);
        chk({pfx, "_e2_cen"}, cen, 0);
        chk({pfx, "_e2_busy"}, busy, 1);
        tick();
        chk({pfx, "_e3_wen"}, wen, 0);
        chk({pfx, "_e3_dat"}, dat, 0);
        chk({pfx, "_e3_done"}, done, 0);
        chk({pfx, "_e3_busy"}, busy, 0);
    endtask

    logic [6:0] e_cen;
    logic [6:0] e_wen;
    logic [6:0] e_done;

    task automatic seq_sample(input int i);
        chk($sformatf("seq%0d_cen", i), cen, e_cen[i]);
        chk($sformatf("seq%0d_wen", i), wen, e_wen[i]);
        chk($sformatf("seq%0d_done", i), done, e_done[i]);
        chk($sformatf("seq%0d_dat", i), dat, (i == 0) ? 32'h10 : 32'h0);
    endtask

    initial begin
        int  acc;
        int  g;
        int  ncen;
        int  ndone;
        int  nwen;
        bit  rdy;
        bit  saw_ready;

        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 8'h00;
        rst_n     = 1'b0;

        // Reset state
        #12;
        chk("rst_cen", cen, 0);
        chk("rst_wen", wen, 0);
        chk("rst_dat", dat, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_ready", cmd_ready, 1);
        #5 rst_n = 1'b1;
        tick();

        // Single LOAD
        load_test("load5a", 8'h5A);

        // LOAD 0x10, RUN 3, NOP, RUN 2 back-to-back
        e_cen  = 7'b1101110;
        e_wen  = 7'b0000001;
        e_done = 7'b1001001;
        push(2'b01, 8'h10);
        push(2'b10, 8'd3);
        push(2'b00, 8'd0);
        seq_sample(0);
        push(2'b10, 8'd2);
        seq_sample(1);
        for (int i = 2; i < 7; i++) begin
            tick();
            seq_sample(i);
        end
        tick();
        chk("seq_end_cen", cen, 0);
        chk("seq_end_busy", busy, 0);

        // Five RUN 200 into a 4-deep FIFO
        acc = 0; g = 0; ncen = 0; ndone = 0; saw_ready = 0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_arg   = 8'd200;
        while (acc < 5 && g < 50) begin
            rdy = cmd_ready;
            tick();
            if (rdy) acc++;
            if (cen) ncen++;
            if (done) ndone++;
            g++;
        end
        cmd_valid = 1'b0;
        chk("fill_accepted", acc, 5);
        chk("fill_level", level, 4);
        chk("fill_ready", cmd_ready, 0);
        g = 0;
        while (busy && g < 1300) begin
            tick();
            if (cen) ncen++;
            if (done) ndone++;
            if (level == 3 && cmd_ready) saw_ready = 1;
            g++;
        end
        chk("fill_drained", busy, 0);
        chk("fill_cen_total", ncen, 1000);
        chk("fill_done_total", ndone, 5);
        chk("fill_ready_back", saw_ready, 1);

        // RUN 250 with two queued, ABORT on the 10th cen cycle
        ncen = 0; ndone = 0; nwen = 0; g = 0;
        push(2'b10, 8'd250);
        push(2'b01, 8'h33);
        push(2'b10, 8'd5);
        chk("abort_level_pre", level, 2);
        while (g < 300) begin
            if (cen) ncen++;
            if (done) ndone++;
            if (ncen == 10) break;
            tick();
            g++;
        end
        push(2'b11, 8'd0);
        for (int i = 0; i < 5; i++) begin
            if (cen) ncen++;
            if (done) ndone++;
            if (wen) nwen++;
            if (i == 0) begin
                chk("abort_level", level, 0);
                chk("abort_busy", busy, 0);
                chk("abort_cen", cen, 0);
            end
            tick();
        end
        chk("abort_cen_total", ncen, 10);
        chk("abort_no_done", ndone, 0);
        chk("abort_no_wen", nwen, 0);

        // RUN 0 then LOAD 7
        push(2'b10, 8'd0);
        push(2'b01, 8'd7);
        chk("r0_e1_cen", cen, 0);
        chk("r0_e1_wen", wen, 0);
        tick();
        chk("r0_slot_cen", cen, 0);
        chk("r0_slot_wen", wen, 0);
        chk("r0_slot_done", done, 0);
        chk("r0_slot_dat", dat, 0);
        chk("r0_slot_busy", busy, 1);
        tick();
        chk("r0_load_wen", wen, 1);
        chk("r0_load_dat", dat, 7);
        chk("r0_load_done", done, 1);
        tick();
        chk("r0_end_wen", wen, 0);
        chk("r0_end_busy", busy, 0);

        // Asynchronous reset pulse mid-RUN 100
        push(2'b10, 8'd100);
        push(2'b01, 8'd9);
        for (int i = 0; i < 20; i++) tick();
        chk("ar_cen_pre", cen, 1);
        chk("ar_level_pre", level, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_cen", cen, 0);
        chk("ar_level", level, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ready", cmd_ready, 1);
        #4 rst_n = 1'b1;
        tick();
        chk("ar_post_cen", cen, 0);
        load_test("ar_load1", 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
